// File: rtl/fp_norm_round_pkg.sv
// Shared definitions for the FP32 adder back end (fp_norm_round).
//  - FSM state encoding (3-bit enum)
//  - Mantissa / fraction / internal exponent widths
//  - Exponent and infinity constants
//  - pack_fp: assembles {sign, exp, frac} into an IEEE-754 single
package fp_norm_round_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADD   = 3'd1,
        ST_NORM  = 3'd2,
        ST_ROUND = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int MANT_W = 48;
    localparam int FRAC_W = 23;
    // Internal exponent is wider than 8 bits so a carry plus a rounding
    // overflow (254 + 1 + 1) cannot wrap before the infinity check.
    localparam int EXP_W  = 10;

    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam logic [31:0] INF_MAG = {1'b0, EXP_MAX, 23'h000000};

    function automatic logic [31:0] pack_fp(input logic sign,
                                            input logic [7:0] exp_field,
                                            input logic [FRAC_W-1:0] frac);
        return {sign, exp_field, frac};
    endfunction

endpackage

// File: rtl/fp_norm_round_rne_round.sv
// rne_round: combinational round-to-nearest-even and IEEE-754 packing.
// Ports:
//  m      in  48  normalized mantissa: [47] hidden bit, [46:24] fraction,
//                 [23] guard, [22:0] sticky bits
//  exp    in  10  biased exponent (1 means denormal range)
//  sign   in  1   result sign
//  result out 32  packed FP32 value
// Configuration: FP_ADD_FTZ_EN flushes denormal results to signed zero.
module rne_round
    import fp_norm_round_pkg::*;
(
    input  logic [MANT_W-1:0] m,
    input  logic [EXP_W-1:0]  exp,
    input  logic              sign,
    output logic [31:0]       result
);

    logic              guard_s;
    logic              sticky_s;
    logic              lsb_s;
    logic              inc_s;
    logic [24:0]       rnd_s;
    logic [23:0]       mant_s;
    logic [EXP_W-1:0]  exp_s;

    // Round the upper 24 bits to nearest-even, then encode the result.
    always_comb begin
        guard_s  = m[23];
        sticky_s = |m[22:0];
        lsb_s    = m[24];
        inc_s    = guard_s && (sticky_s || lsb_s);
        rnd_s    = {1'b0, m[47:24]} + {24'd0, inc_s};
        mant_s   = rnd_s[23:0];
        exp_s    = exp;
        // 1.111..1 rounding up wraps to 1.0 in the next binade.
        if (rnd_s[24]) begin
            mant_s = 24'h800000;
            exp_s  = exp + 10'd1;
        end else begin
            mant_s = rnd_s[23:0];
            exp_s  = exp;
        end

        if (exp_s >= {2'b00, EXP_MAX}) begin
            result = INF_MAG | {sign, 31'd0};
        end else if (!mant_s[23]) begin
            // No hidden bit: only reachable with exp==1, i.e. a denormal.
            // A denormal that rounds into bit 23 takes the branch below
            // and gets exponent field 1.
            result = pack_fp(sign, 8'd0, mant_s[22:0]);
        end else begin
            result = pack_fp(sign, exp_s[7:0], mant_s[22:0]);
        end

`ifdef FP_ADD_FTZ_EN
        if ((result[30:23] == 8'd0) && (result[22:0] != 23'd0)) begin
            result = {sign, 31'd0};
        end else begin
            result = result;
        end
`endif
    end

endmodule

// File: rtl/fp_norm_round.sv
// fp_norm_round: FP32 adder back end. Adds/subtracts two aligned 48-bit
// mantissas, normalizes iteratively (up to NORM_STEP positions per cycle),
// rounds to nearest-even and returns the packed single over valid/ready.
// One operation in flight; latency from accept to out_valid is 3 + NORM cycles.
// Parameters:
//  NORM_STEP  max left shift per NORM cycle (1, 2, 4 or 8)
// Ports:
//  clk, rst            clock (rising edge), asynchronous active-high reset
//  in_valid/in_ready   operand handshake
//  sign_op_1/2         operand signs
//  exp_res             biased exponent of the larger operand
//  op_1_f_pr/op_2_f_pr aligned mantissas: [47] hidden, [46:24] frac, [23:0] shifted-out
//  out_valid/out_ready result handshake
//  result              packed FP32 {sign, exp, frac}
// Configuration: FP_ADD_FTZ_EN (in rne_round) flushes denormal results to zero.
module fp_norm_round
    import fp_norm_round_pkg::*;
#(
    parameter int NORM_STEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_op_1,
    input  logic              sign_op_2,
    input  logic [7:0]        exp_res,
    input  logic [MANT_W-1:0] op_1_f_pr,
    input  logic [MANT_W-1:0] op_2_f_pr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       result
);

    state_t            state_r, state_next_s;
    logic              sign1_r, sign2_r;
    logic [7:0]        exp_in_r;
    logic [MANT_W-1:0] a_r, b_r;
    logic [MANT_W-1:0] m_r;
    logic [EXP_W-1:0]  exp_r;
    logic              sign_r;
    logic              zero_r;
    logic [31:0]       result_r;
    logic              out_valid_r;
    logic              in_ready_r;

    logic [MANT_W:0]   sum_s;
    logic [MANT_W-1:0] add_m_s;
    logic [EXP_W-1:0]  add_exp_s;
    logic              add_sign_s;
    logic              add_zero_s;
    int unsigned       norm_sh_s;
    logic [MANT_W-1:0] norm_m_s;
    logic [EXP_W-1:0]  norm_exp_s;
    logic [31:0]       round_result_s;

    // Largest shift <= NORM_STEP that neither passes the leading one nor
    // drives the exponent below 1.
    function automatic int unsigned norm_shift(input logic [MANT_W-1:0] m,
                                               input logic [EXP_W-1:0] e);
        int unsigned sh;
        sh = 0;
        for (int i = 1; i <= NORM_STEP; i++) begin
            if (((m >> (MANT_W - i)) == 48'd0) && (e > EXP_W'(i))) begin
                sh = i;
            end else begin
                sh = sh;
            end
        end
        return sh;
    endfunction

    // Signed-magnitude add/subtract of the latched operands.
    always_comb begin
        sum_s      = {1'b0, a_r} + {1'b0, b_r};
        add_m_s    = 48'd0;
        add_exp_s  = {2'b00, exp_in_r};
        add_sign_s = sign1_r;
        if (sign1_r == sign2_r) begin
            if (sum_s[MANT_W]) begin
                // Carry out: shift right, keep the lost bit as sticky.
                add_m_s   = sum_s[MANT_W:1] | {47'd0, sum_s[0]};
                add_exp_s = {2'b00, exp_in_r} + 10'd1;
            end else begin
                add_m_s   = sum_s[MANT_W-1:0];
                add_exp_s = {2'b00, exp_in_r};
            end
            add_sign_s = sign1_r;
        end else if (a_r >= b_r) begin
            add_m_s    = a_r - b_r;
            add_sign_s = sign1_r;
        end else begin
            add_m_s    = b_r - a_r;
            add_sign_s = sign2_r;
        end
        add_zero_s = (add_m_s == 48'd0);
        // Exact cancellation always yields +0.
        if (add_zero_s) begin
            add_sign_s = 1'b0;
        end else begin
            add_sign_s = add_sign_s;
        end
    end

    // One normalization step on the working mantissa.
    always_comb begin
        norm_sh_s  = norm_shift(m_r, exp_r);
        norm_m_s   = m_r << norm_sh_s;
        norm_exp_s = exp_r - EXP_W'(norm_sh_s);
    end

    rne_round u_rne_round (
        .m      (m_r),
        .exp    (exp_r),
        .sign   (sign_r),
        .result (round_result_s)
    );

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) state_next_s = ST_ADD;
                else          state_next_s = ST_IDLE;
            end
            ST_ADD: begin
                // A zero sum skips normalization; it still passes ROUND so
                // every operation takes at least 3 cycles.
                if (add_zero_s || add_m_s[MANT_W-1] || (add_exp_s <= 10'd1))
                    state_next_s = ST_ROUND;
                else
                    state_next_s = ST_NORM;
            end
            ST_NORM: begin
                if (norm_m_s[MANT_W-1] || (norm_exp_s <= 10'd1))
                    state_next_s = ST_ROUND;
                else
                    state_next_s = ST_NORM;
            end
            ST_ROUND: state_next_s = ST_DONE;
            ST_DONE: begin
                if (out_ready) state_next_s = ST_IDLE;
                else           state_next_s = ST_DONE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            out_valid_r <= (state_next_s == ST_DONE);
            in_ready_r  <= (state_next_s == ST_IDLE);
        end
    end

    // Datapath registers: operand capture, working mantissa/exponent, result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign1_r  <= 1'b0;
            sign2_r  <= 1'b0;
            exp_in_r <= 8'd0;
            a_r      <= 48'd0;
            b_r      <= 48'd0;
            m_r      <= 48'd0;
            exp_r    <= 10'd0;
            sign_r   <= 1'b0;
            zero_r   <= 1'b0;
            result_r <= 32'h00000000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        sign1_r  <= sign_op_1;
                        sign2_r  <= sign_op_2;
                        exp_in_r <= exp_res;
                        a_r      <= op_1_f_pr;
                        b_r      <= op_2_f_pr;
                    end
                end
                ST_ADD: begin
                    m_r    <= add_m_s;
                    exp_r  <= add_exp_s;
                    sign_r <= add_sign_s;
                    zero_r <= add_zero_s;
                end
                ST_NORM: begin
                    m_r   <= norm_m_s;
                    exp_r <= norm_exp_s;
                end
                ST_ROUND: begin
                    result_r <= zero_r ? 32'h00000000 : round_result_s;
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed testbench for fp_norm_round (default NORM_STEP = 1).
// Expected results are hand-computed FP32 encodings; denormal expectations
// follow FP_ADD_FTZ_EN when it is defined.
module tb_fp_norm_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sign_op_1;
    logic        sign_op_2;
    logic [7:0]  exp_res;
    logic [47:0] op_1_f_pr;
    logic [47:0] op_2_f_pr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fp_norm_round dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_op_1 (sign_op_1),
        .sign_op_2 (sign_op_2),
        .exp_res   (exp_res),
        .op_1_f_pr (op_1_f_pr),
        .op_2_f_pr (op_2_f_pr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Issue one operation (caller is #1 after a posedge with in_ready high),
    // scramble the inputs after accept, wait for out_valid, check latency and
    // result, hold out_ready low for 'hold' cycles, then complete the handshake.
    task automatic run_op(input string tag, input logic s1, input logic s2,
                          input logic [7:0] e, input logic [47:0] a, input logic [47:0] b,
                          input logic [31:0] exp_result, input int exp_lat, input int hold);
        int cyc;
        sign_op_1 = s1; sign_op_2 = s2; exp_res = e;
        op_1_f_pr = a;  op_2_f_pr = b;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        sign_op_1 = ~s1; sign_op_2 = s2; exp_res = 8'h55;
        op_1_f_pr = 48'hDEAD_BEEF_1234; op_2_f_pr = 48'h0F0F_0F0F_0F0F;
        check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_lat"}, cyc, exp_lat);
        check({tag, "_res"}, result, exp_result);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check({tag, "_hold_res"}, result, exp_result);
            check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_hold_rdy"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
    endtask

    logic [31:0] exp_den;
    logic [31:0] exp_den2;
    int          seen_valid;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        sign_op_1 = 1'b0; sign_op_2 = 1'b0; exp_res = 8'd0;
        op_1_f_pr = 48'd0; op_2_f_pr = 48'd0;
`ifdef FP_ADD_FTZ_EN
        exp_den  = 32'h00000000;
        exp_den2 = 32'h00000000;
`else
        exp_den  = 32'h00400000;
        exp_den2 = 32'h00000004;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_result", result, 32'h00000000);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("one_plus_one", 1'b0, 1'b0, 8'd127, 48'h800000000000, 48'h800000000000, 32'h40000000, 3, 0);
        run_op("one_minus_half", 1'b0, 1'b1, 8'd127, 48'h800000000000, 48'h400000000000, 32'h3F000000, 4, 0);
        run_op("one_minus_one", 1'b0, 1'b1, 8'd127, 48'h800000000000, 48'h800000000000, 32'h00000000, 3, 0);
        run_op("tie_even", 1'b0, 1'b0, 8'd127, 48'h800000000000, 48'h000000800000, 32'h3F800000, 3, 4);
        run_op("tie_odd", 1'b0, 1'b0, 8'd127, 48'h800001000000, 48'h000000800000, 32'h3F800002, 3, 0);
        run_op("sticky_up", 1'b0, 1'b0, 8'd127, 48'h800000000000, 48'h000000C00000, 32'h3F800001, 3, 0);
        run_op("overflow", 1'b0, 1'b0, 8'd254, 48'h800000000000, 48'h800000000000, 32'h7F800000, 3, 0);
        run_op("neg_sum", 1'b1, 1'b1, 8'd127, 48'h800000000000, 48'h800000000000, 32'hC0000000, 3, 0);
        run_op("op2_larger", 1'b0, 1'b1, 8'd127, 48'h400000000000, 48'h800000000000, 32'hBF000000, 4, 0);
        run_op("round_carry", 1'b0, 1'b0, 8'd127, 48'hFFFFFF800000, 48'h000000000000, 32'h40000000, 3, 0);
        run_op("long_norm", 1'b0, 1'b1, 8'd127, 48'h800000000000, 48'h7FFFFF000000, 32'h34000000, 26, 0);
        run_op("denormal", 1'b0, 1'b0, 8'd1, 48'h400000000000, 48'h000000000000, exp_den, 3, 0);
        run_op("norm_to_denorm", 1'b0, 1'b1, 8'd3, 48'h800000000000, 48'h7FFFFF000000, exp_den2, 5, 0);
        run_op("denorm_round_up", 1'b0, 1'b0, 8'd1, 48'h7FFFFF800000, 48'h000000000001, 32'h00800000, 3, 0);

        // Reset while the long normalization is in progress.
        sign_op_1 = 1'b0; sign_op_2 = 1'b1; exp_res = 8'd127;
        op_1_f_pr = 48'h800000000000; op_2_f_pr = 48'h7FFFFF000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_busy", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        #2;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_result", result, 32'h00000000);
        rst = 1'b0;
        seen_valid = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid++;
        end
        check("no_stale_result", seen_valid, 0);
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);

        run_op("after_reset", 1'b0, 1'b0, 8'd127, 48'h800000000000, 48'h800000000000, 32'h40000000, 3, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
